// File: rtl/mux_extension_pkg.sv
// -----------------------------------------------------------------------------
// mux_extension_pkg
// Shared definitions for the ALU second-operand select stage.
//   DATA_W    : default datapath width
//   SEL_RS1   : ALUSrc encoding selecting the register operand
//   SEL_EXT   : ALUSrc encoding selecting the sign-extended immediate
//   operand_t : one datapath operand
// -----------------------------------------------------------------------------
package mux_extension_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic SEL_RS1 = 1'b0;
    localparam logic SEL_EXT = 1'b1;

    typedef logic [DATA_W-1:0] operand_t;

endpackage : mux_extension_pkg

// File: rtl/mux2_w.sv
// -----------------------------------------------------------------------------
// mux2_w
// Parameterised combinational 2:1 multiplexer.
//   WIDTH : data width
//   a     : in,  WIDTH - selected when sel == SEL_RS1
//   b     : in,  WIDTH - selected when sel == SEL_EXT
//   sel   : in,  1     - select
//   y     : out, WIDTH - selected data, all bits unmodified
// -----------------------------------------------------------------------------
module mux2_w
    import mux_extension_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select resolves to the a input, matching hardware that
    // decodes only the SEL_EXT pattern.
    always_comb begin
        y = a;
        if (sel == SEL_EXT) begin
            y = b;
        end
    end

endmodule : mux2_w

// File: rtl/mux_extension_stage.sv
// -----------------------------------------------------------------------------
// mux_extension_stage
// ALU second-operand select: picks the sign-extended immediate or the register
// operand and presents it to the ALU through one pipeline register with
// valid/stall control.
//
// Build option: define MUX_EXTENSION_COMB_EN to remove the register stage;
// outputs then follow the inputs combinationally and clk/rst/stall are unused.
//
// Ports:
//   clk             : in,  1     - rising-edge clock
//   rst             : in,  1     - asynchronous, active-high reset
//   stall           : in,  1     - hold all pipeline registers
//   in_valid        : in,  1     - inputs carry a live operand
//   extension_signo : in,  WIDTH - sign-extended immediate
//   RS1             : in,  WIDTH - register operand
//   ALUSrc          : in,  1     - 1 selects extension_signo, 0 selects RS1
//   out_mux_exte    : out, WIDTH - selected operand
//   out_valid       : out, 1     - out_mux_exte is live
//   out_sel         : out, 1     - ALUSrc value that produced out_mux_exte
// -----------------------------------------------------------------------------
module mux_extension_stage
    import mux_extension_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] extension_signo,
    input  logic [WIDTH-1:0] RS1,
    input  logic             ALUSrc,
    output logic [WIDTH-1:0] out_mux_exte,
    output logic             out_valid,
    output logic             out_sel
);

    logic [WIDTH-1:0] mux;
    logic             sel_norm;

    mux2_w #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a  (RS1),
        .b  (extension_signo),
        .sel(ALUSrc),
        .y  (mux)
    );

    // Unknown ALUSrc is recorded as SEL_RS1 so out_sel agrees with the data.
    always_comb begin
        sel_norm = SEL_RS1;
        if (ALUSrc == SEL_EXT) begin
            sel_norm = SEL_EXT;
        end
    end

    always_comb begin
        if (in_valid) begin
            assert (!$isunknown(ALUSrc))
                else $error("ALUSrc unknown while in_valid is high");
        end
    end

`ifdef MUX_EXTENSION_COMB_EN

    assign out_mux_exte = mux;
    assign out_valid    = in_valid;
    assign out_sel      = sel_norm;

`else

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sel_q, sel_d;

    // Data and select only load on a live operand so bubbles leave them
    // untouched; valid drops on a bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (!stall) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = mux;
                sel_d  = sel_norm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= SEL_RS1;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign out_mux_exte = data_q;
    assign out_valid    = valid_q;
    assign out_sel      = sel_q;

`endif

endmodule : mux_extension_stage

// File: tb/tb_mux_extension_stage.sv
module tb_mux_extension_stage;
    import mux_extension_pkg::*;

    logic     clk;
    logic     rst;
    logic     stall;
    logic     in_valid;
    operand_t extension_signo;
    operand_t RS1;
    logic     ALUSrc;
    operand_t out_mux_exte;
    logic     out_valid;
    logic     out_sel;

    int unsigned total;
    int unsigned bad;

    mux_extension_stage #(
        .WIDTH(DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .in_valid       (in_valid),
        .extension_signo(extension_signo),
        .RS1            (RS1),
        .ALUSrc         (ALUSrc),
        .out_mux_exte   (out_mux_exte),
        .out_valid      (out_valid),
        .out_sel        (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input operand_t ext, input operand_t r, input logic s);
        in_valid        = v;
        extension_signo = ext;
        RS1             = r;
        ALUSrc          = s;
    endtask

`ifdef MUX_EXTENSION_COMB_EN

    task automatic test_comb();
        operand_t ext_v [4];
        operand_t rs1_v [4];
        logic     sel_v [4];
        operand_t exp_v [4];
        ext_v = '{32'h00000000, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0000FFFF};
        rs1_v = '{32'h7FFFFFFF, 32'h55555555, 32'h12345678, 32'hFFFF0000};
        sel_v = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_v = '{32'h00000000, 32'hAAAAAAAA, 32'h12345678, 32'hFFFF0000};
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ext_v[i], rs1_v[i], sel_v[i]);
            #1;
            total++;
            if (out_mux_exte !== exp_v[i]) begin
                bad++;
                $display("FAIL comb_data%0d got=%h exp=%h", i, out_mux_exte, exp_v[i]);
            end
            total++;
            if (out_sel !== sel_v[i]) begin
                bad++;
                $display("FAIL comb_sel%0d got=%b exp=%b", i, out_sel, sel_v[i]);
            end
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL comb_valid%0d got=%b exp=1", i, out_valid);
            end
            #9;
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL comb_valid_low got=%b exp=0", out_valid);
        end
        stall = 1'b0;
    endtask

`else

    task automatic test_reset();
        total++;
        if (out_mux_exte !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=00000000", out_mux_exte);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_sel got=%b exp=0", out_sel);
        end
        // Idle edge after reset release: nothing captured.
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_select_imm();
        drive(1'b1, 32'h00000000, 32'h7FFFFFFF, 1'b1);
        tick();
        total++;
        if (out_mux_exte !== 32'h00000000) begin
            bad++;
            $display("FAIL imm0_data got=%h exp=00000000", out_mux_exte);
        end
        total++;
        if (out_sel !== 1'b1) begin
            bad++;
            $display("FAIL imm0_sel got=%b exp=1", out_sel);
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL imm0_valid got=%b exp=1", out_valid);
        end
        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1);
        tick();
        total++;
        if (out_mux_exte !== 32'hAAAAAAAA) begin
            bad++;
            $display("FAIL imm1_data got=%h exp=aaaaaaaa", out_mux_exte);
        end
    endtask

    task automatic test_select_reg();
        drive(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        tick();
        total++;
        if (out_mux_exte !== 32'h12345678) begin
            bad++;
            $display("FAIL reg0_data got=%h exp=12345678", out_mux_exte);
        end
        total++;
        if (out_sel !== 1'b0) begin
            bad++;
            $display("FAIL reg0_sel got=%b exp=0", out_sel);
        end
        drive(1'b1, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
        tick();
        total++;
        if (out_mux_exte !== 32'hFFFF0000) begin
            bad++;
            $display("FAIL reg1_data got=%h exp=ffff0000", out_mux_exte);
        end
    endtask

    task automatic test_bubble();
        // Inputs change during the bubble but must not be loaded.
        drive(1'b0, 32'h13572468, 32'h0BADF00D, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bubble_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_mux_exte !== 32'hFFFF0000) begin
            bad++;
            $display("FAIL bubble_data got=%h exp=ffff0000", out_mux_exte);
        end
        total++;
        if (out_sel !== 1'b0) begin
            bad++;
            $display("FAIL bubble_sel got=%b exp=0", out_sel);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        tick();
        total++;
        if (out_mux_exte !== 32'h12345678) begin
            bad++;
            $display("FAIL stall_pre_data got=%h exp=12345678", out_mux_exte);
        end
        stall = 1'b1;
        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_mux_exte !== 32'h12345678) begin
                bad++;
                $display("FAIL stall_hold_data%0d got=%h exp=12345678", i, out_mux_exte);
            end
            total++;
            if (out_valid !== 1'b1 || out_sel !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_ctl%0d got=v%b s%b exp=v1 s0", i, out_valid, out_sel);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (out_mux_exte !== 32'hAAAAAAAA || out_sel !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got=%h s%b exp=aaaaaaaa s1", out_mux_exte, out_sel);
        end
        // Stall also holds a low valid across a pending live input.
        in_valid = 1'b0;
        tick();
        stall = 1'b1;
        drive(1'b1, 32'h11111111, 32'h22222222, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || out_mux_exte !== 32'hAAAAAAAA) begin
            bad++;
            $display("FAIL stall_bubble got=v%b %h exp=v0 aaaaaaaa", out_valid, out_mux_exte);
        end
        stall = 1'b0;
        tick();
        total++;
        if (out_mux_exte !== 32'h22222222 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_bubble_release got=v%b %h exp=v1 22222222", out_valid, out_mux_exte);
        end
    endtask

    task automatic test_back_to_back();
        operand_t ext_v [4];
        operand_t rs1_v [4];
        logic     sel_v [4];
        operand_t exp_v [4];
        ext_v = '{32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'hCAFEF00D};
        rs1_v = '{32'h01234567, 32'hFEDCBA98, 32'h7FFFFFFF, 32'h00000000};
        sel_v = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_v = '{32'hDEADBEEF, 32'hFEDCBA98, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ext_v[i], rs1_v[i], sel_v[i]);
            tick();
            total++;
            if (out_mux_exte !== exp_v[i] || out_sel !== sel_v[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d got=%h s%b v%b exp=%h s%b v1",
                         i, out_mux_exte, out_sel, out_valid, exp_v[i], sel_v[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h5A5A5A5A, 32'h0F0F0F0F, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_mux_exte !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL areset_pre got=v%b %h exp=v1 5a5a5a5a", out_valid, out_mux_exte);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (out_mux_exte !== 32'h0 || out_valid !== 1'b0 || out_sel !== 1'b0) begin
            bad++;
            $display("FAIL areset_immediate got=%h v%b s%b exp=0 v0 s0", out_mux_exte, out_valid, out_sel);
        end
        // Reset wins over stall and over a live input across an edge.
        stall = 1'b1;
        tick();
        total++;
        if (out_mux_exte !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL areset_held got=%h v%b exp=0 v0", out_mux_exte, out_valid);
        end
        rst   = 1'b0;
        stall = 1'b0;
        drive(1'b1, 32'h00000ABC, 32'h00000DEF, 1'b0);
        tick();
        total++;
        if (out_mux_exte !== 32'h00000DEF || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_first_capture got=%h v%b exp=00000def v1", out_mux_exte, out_valid);
        end
    endtask

`endif

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
`ifdef MUX_EXTENSION_COMB_EN
        rst = 1'b0;
        #1;
        test_comb();
`else
        #1;
        test_reset();
        test_select_imm();
        test_select_reg();
        test_bubble();
        test_stall();
        test_back_to_back();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_extension_stage

// File: doc/mux_extension_stage.md
# mux_extension_stage

ALU second-operand select stage of the RISC-V datapath, between the register file / immediate generator and the ALU. Selects either the sign-extended immediate (`extension_signo`) or the register operand (`RS1`) under control of `ALUSrc`. Drives the result to the ALU through a one-cycle pipeline register with valid and stall control.

## Interface
Parameters:
- `WIDTH`, default 32: data width of both operands and the output.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: when 1, all pipeline registers hold.
- `in_valid` input 1: the inputs carry a live operand this cycle.
- `extension_signo` input WIDTH: sign-extended immediate.
- `RS1` input WIDTH: register operand.
- `ALUSrc` input 1: 1 selects `extension_signo`; 0 selects `RS1`.
- `out_mux_exte` output WIDTH: selected operand, registered.
- `out_valid` output 1: `out_mux_exte` holds a live operand.
- `out_sel` output 1: registered copy of the `ALUSrc` value that produced `out_mux_exte`.

## Operation
Selection is a pure 2:1 mux:
- `ALUSrc=1` gives `mux = extension_signo`.
- `ALUSrc=0` gives `mux = RS1`.
- No arithmetic, no width change. All WIDTH bits pass unmodified.

Register update on each rising edge, with `rst` low:
- `stall=1`: `out_mux_exte`, `out_valid` and `out_sel` hold.
- `stall=0`, `in_valid=1`: `out_mux_exte <= mux`, `out_sel <= ALUSrc`, `out_valid <= 1`.
- `stall=0`, `in_valid=0`: `out_valid <= 0`. `out_mux_exte` and `out_sel` hold their last values, so there is no data toggling on bubbles.

Other rules:
- X or Z on `ALUSrc` while `in_valid=1` is a caller error. A simulation assertion flags it. Synthesis treats the value as 0.
- No state machine. The block is a single register stage.

## Timing
- Latency: 1 cycle from input to `out_mux_exte`/`out_valid`.
- Throughput: one operand per cycle while `stall=0`.
- Reset values:
  - `out_mux_exte = 0`
  - `out_valid = 0`
  - `out_sel = 0`
- `rst` is asynchronous: outputs clear immediately on assertion, including mid-transfer. The operand in flight is discarded.
- After `rst` deasserts, the first capture happens on the first rising edge with `stall=0` and `in_valid=1`.
- `stall` and `in_valid` both high: `stall` wins and the input is not captured. The producer holds its inputs stable while stalled.
- `rst` and `stall` both high: `rst` wins.
- Inputs are sampled only at the clock edge. Combinational glitches on `ALUSrc` between edges have no effect.

## Configuration
- `MUX_EXTENSION_COMB_EN` defined:
  - The register stage is compiled out.
  - `out_mux_exte = mux`, `out_valid = in_valid`, `out_sel = ALUSrc`, all combinational with 0-cycle latency.
  - `clk`, `rst` and `stall` remain as ports but are unused.
- `MUX_EXTENSION_COMB_EN` not defined: registered behaviour as described above (default).

## Structure
- Shared package `mux_extension_pkg`:
  - `DATA_W = 32`.
  - Select encodings `SEL_RS1 = 1'b0` and `SEL_EXT = 1'b1`.
  - Typedef `operand_t` (logic [DATA_W-1:0]).
- One combinational sub-module, `mux2_w` (parameter WIDTH; ports `a`, `b`, `sel`, `y`), instantiated once for the operand select.
- Top level `mux_extension_stage` holds the register stage and the configuration branch.

## Test plan
- Reset: assert `rst` mid-run with `out_valid=1` -> `out_mux_exte=0`, `out_valid=0` and `out_sel=0` immediately, without waiting for a clock edge.
- Select immediate: `extension_signo=0x00000000`, `RS1=0x7FFFFFFF`, `ALUSrc=1`, `in_valid=1` -> next edge `out_mux_exte=0x00000000`, `out_sel=1`. Then `0xAAAAAAAA`/`0x55555555`, `ALUSrc=1` -> `0xAAAAAAAA`.
- Select register: `extension_signo=0xFFFFFFFF`, `RS1=0x12345678`, `ALUSrc=0` -> `out_mux_exte=0x12345678`. Then `0x0000FFFF`/`0xFFFF0000`, `ALUSrc=0` -> `0xFFFF0000`.
- Stall hold: capture `0x12345678`, then `stall=1` with new inputs `0xAAAAAAAA`, `ALUSrc=1` for 3 cycles -> output stays `0x12345678` with `out_valid=1`. Release `stall` -> `0xAAAAAAAA` one edge later.
- Bubble: `in_valid=0` after capturing `0xFFFF0000` -> `out_valid=0` and `out_mux_exte` stays `0xFFFF0000`.
- `MUX_EXTENSION_COMB_EN` build: repeat the four select vectors at 10 ns spacing -> `out_mux_exte` follows the inputs within the same time step, with no clock edge required.
